// File: rtl/ysyx_25060170_lsu.sv
// Load/store unit between EXU and WBU: one outstanding bus transaction,
// sub-word store lane replication, load extraction/extension, misalign and timeout.
module ysyx_25060170_lsu #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exu_valid_i,
    output logic        lsu_ready_o,
    input  logic [31:0] exu_result_i,
    input  logic [31:0] store_data_i,
    input  logic [1:0]  mem_op_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_unsigned_i,
    input  logic [4:0]  rd_i,
    input  logic [1:0]  regS_i,
    input  logic        RegW_i,
    input  logic [31:0] PC_i,
    output logic        wbu_valid_o,
    input  logic        wbu_ready_i,
    output logic [31:0] wbu_result_o,
    output logic [4:0]  wbu_rd_o,
    output logic [1:0]  wbu_regS_o,
    output logic        wbu_RegW_o,
    output logic [31:0] wbu_PC_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        misalign_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_OUT} state_t;

    // Timeout fires on the edge where the counter would reach MAX_WAIT.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    function automatic logic misaligned(input logic [1:0] off, input logic [1:0] size);
        case (size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = off[0];
            default: misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [31:0] data, input logic [1:0] size);
        case (size)
            2'd0:    store_lanes = {4{data[7:0]}};
            2'd1:    store_lanes = {2{data[15:0]}};
            default: store_lanes = data;
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(input logic [1:0] off, input logic [1:0] size);
        case (size)
            2'd0:    store_strobe = 4'b0001 << off;
            2'd1:    store_strobe = 4'b0011 << off;
            default: store_strobe = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] off,
                                                input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{off, 3'b000} +: 8];
        h = rdata[{off[1], 4'b0000} +: 16];
        case (size)
            2'd0:    load_extend = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'd1:    load_extend = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: load_extend = rdata;
        endcase
    endfunction

    state_t      state_r, next_s;
    logic [7:0]  cnt_r;
    logic        ready_r, valid_r, req_r, we_r, misal_r, timeout_r;
    logic        accept_s, go_timeout_s, is_mem_s, misal_s, store_s;
    logic [31:0] result_r, pc_r, addr_r, wdata_r;
    logic [4:0]  rd_r;
    logic [1:0]  regs_r, op_r, size_r, off_r;
    logic        regw_r, uns_r;
    logic [3:0]  wstrb_r;

    // Next-state decode and accept/timeout qualification.
    always_comb begin
        next_s       = state_r;
        accept_s     = 1'b0;
        go_timeout_s = 1'b0;
        is_mem_s     = (mem_op_i == 2'd1) || (mem_op_i == 2'd2);
        misal_s      = is_mem_s && misaligned(exu_result_i[1:0], mem_size_i);
        store_s      = (state_r == ST_IDLE) ? (mem_op_i == 2'd2) : (op_r == 2'd2);
        case (state_r)
            ST_IDLE: begin
                if (exu_valid_i && ready_r) begin
                    accept_s = 1'b1;
                    if (is_mem_s && !misal_s) next_s = ST_REQ;
                    else                      next_s = ST_OUT;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_gnt_i) begin
                    next_s = ST_WAIT;
                end else if (cnt_r == WAIT_LAST) begin
                    next_s       = ST_OUT;
                    go_timeout_s = 1'b1;
                end else begin
                    next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    next_s = ST_OUT;
                end else if (cnt_r == WAIT_LAST) begin
                    next_s       = ST_OUT;
                    go_timeout_s = 1'b1;
                end else begin
                    next_s = ST_WAIT;
                end
            end
            ST_OUT: begin
                if (wbu_ready_i) next_s = ST_IDLE;
                else             next_s = ST_OUT;
            end
            default: next_s = ST_IDLE;
        endcase
    end

    // State register, wait counter and registered handshake/status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 8'd0;
            ready_r   <= 1'b0;
            valid_r   <= 1'b0;
            req_r     <= 1'b0;
            we_r      <= 1'b0;
            misal_r   <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r <= next_s;
            ready_r <= (next_s == ST_IDLE);
            valid_r <= (next_s == ST_OUT);
            req_r   <= (next_s == ST_REQ);
            we_r    <= (next_s == ST_REQ) && store_s;
            if (accept_s)                                     cnt_r <= 8'd0;
            else if (state_r == ST_REQ || state_r == ST_WAIT) cnt_r <= cnt_r + 8'd1;
            if (accept_s)                                misal_r <= misal_s;
            else if (state_r == ST_OUT && wbu_ready_i)   misal_r <= 1'b0;
            if (go_timeout_s)                            timeout_r <= 1'b1;
            else if (state_r == ST_OUT && wbu_ready_i)   timeout_r <= 1'b0;
        end
    end

    // Transaction latch at accept; load data and timeout squash update it later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_r <= 32'h0;
            pc_r     <= 32'h0;
            rd_r     <= 5'd0;
            regs_r   <= 2'd0;
            regw_r   <= 1'b0;
            op_r     <= 2'd0;
            size_r   <= 2'd0;
            uns_r    <= 1'b0;
            off_r    <= 2'd0;
            addr_r   <= 32'h0;
            wdata_r  <= 32'h0;
            wstrb_r  <= 4'h0;
        end else if (accept_s) begin
            result_r <= exu_result_i;
            pc_r     <= PC_i;
            rd_r     <= rd_i;
            regs_r   <= (mem_op_i == 2'd1) ? 2'd0 : regS_i;
            regw_r   <= RegW_i && (mem_op_i != 2'd2) && !misal_s;
            op_r     <= mem_op_i;
            size_r   <= mem_size_i;
            uns_r    <= mem_unsigned_i;
            off_r    <= exu_result_i[1:0];
            addr_r   <= {exu_result_i[31:2], 2'b00};
            wdata_r  <= store_lanes(store_data_i, mem_size_i);
            wstrb_r  <= (mem_op_i == 2'd2) ? store_strobe(exu_result_i[1:0], mem_size_i) : 4'b0000;
        end else if (state_r == ST_WAIT && mem_rvalid_i && op_r == 2'd1) begin
            result_r <= load_extend(mem_rdata_i, off_r, size_r, uns_r);
        end else if (go_timeout_s) begin
            regw_r <= 1'b0;
        end
    end

    assign lsu_ready_o  = ready_r;
    assign wbu_valid_o  = valid_r;
    assign wbu_result_o = result_r;
    assign wbu_rd_o     = rd_r;
    assign wbu_regS_o   = regs_r;
    assign wbu_RegW_o   = regw_r;
    assign wbu_PC_o     = pc_r;
    assign mem_req_o    = req_r;
    assign mem_we_o     = we_r;
    assign mem_addr_o   = addr_r;
    assign mem_wdata_o  = wdata_r;
    assign mem_wstrb_o  = wstrb_r;
    assign misalign_o   = misal_r;
    assign timeout_o    = timeout_r;

endmodule

// File: tb/tb_ysyx_25060170_lsu.sv
// Directed bench for the LSU: transaction-level expectation model checked every
// cycle, plus literal expectations for the reference scenarios.
module tb_ysyx_25060170_lsu;

    localparam int TB_MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        exu_valid_i, lsu_ready_o;
    logic [31:0] exu_result_i, store_data_i, PC_i;
    logic [1:0]  mem_op_i, mem_size_i, regS_i;
    logic        mem_unsigned_i, RegW_i;
    logic [4:0]  rd_i;
    logic        wbu_valid_o, wbu_ready_i;
    logic [31:0] wbu_result_o, wbu_PC_o;
    logic [4:0]  wbu_rd_o;
    logic [1:0]  wbu_regS_o;
    logic        wbu_RegW_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_wstrb_o;
    logic        mem_gnt_i, mem_rvalid_i, misalign_o, timeout_o;

    always #5 clk = ~clk;

    ysyx_25060170_lsu #(.MAX_WAIT(TB_MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .exu_valid_i(exu_valid_i), .lsu_ready_o(lsu_ready_o),
        .exu_result_i(exu_result_i), .store_data_i(store_data_i),
        .mem_op_i(mem_op_i), .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
        .rd_i(rd_i), .regS_i(regS_i), .RegW_i(RegW_i), .PC_i(PC_i),
        .wbu_valid_o(wbu_valid_o), .wbu_ready_i(wbu_ready_i),
        .wbu_result_o(wbu_result_o), .wbu_rd_o(wbu_rd_o), .wbu_regS_o(wbu_regS_o),
        .wbu_RegW_o(wbu_RegW_o), .wbu_PC_o(wbu_PC_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .misalign_o(misalign_o), .timeout_o(timeout_o)
    );

    int checks = 0;
    int errors = 0;

    // Expectation for the transaction in flight.
    bit          exp_wb_armed = 1'b0, exp_mem_armed = 1'b0, exp_chk_result = 1'b0;
    logic [31:0] exp_result, exp_pc, exp_addr, exp_wdata;
    logic [4:0]  exp_rd;
    logic [1:0]  exp_regs;
    logic        exp_regw, exp_mis, exp_to, exp_we;
    logic [3:0]  exp_wstrb;

    // Values observed from the DUT for literal pinning.
    logic [31:0] cap_result, cap_addr, cap_wdata;
    logic [4:0]  cap_rd;
    logic [1:0]  cap_regs;
    logic [3:0]  cap_wstrb;
    logic        cap_regw, cap_mis, cap_to, cap_we, saw_req;
    int          last_lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the current expectation.
    task automatic monitor();
        if (rst) begin
            if (wbu_valid_o) begin
                chk1("wb_expected", 1'b1, logic'(exp_wb_armed));
                if (exp_wb_armed) begin
                    if (exp_chk_result) chk("wb_result", wbu_result_o, exp_result);
                    chk("wb_rd", 32'(wbu_rd_o), 32'(exp_rd));
                    chk("wb_regS", 32'(wbu_regS_o), 32'(exp_regs));
                    chk1("wb_RegW", wbu_RegW_o, exp_regw);
                    chk("wb_PC", wbu_PC_o, exp_pc);
                    chk1("misalign", misalign_o, exp_mis);
                    chk1("timeout", timeout_o, exp_to);
                end
                cap_result = wbu_result_o; cap_rd = wbu_rd_o; cap_regs = wbu_regS_o;
                cap_regw = wbu_RegW_o; cap_mis = misalign_o; cap_to = timeout_o;
            end else begin
                chk1("misalign_idle", misalign_o, 1'b0);
                chk1("timeout_idle", timeout_o, 1'b0);
            end
            if (mem_req_o) begin
                chk1("req_expected", 1'b1, logic'(exp_mem_armed));
                if (exp_mem_armed) begin
                    chk("mem_addr", mem_addr_o, exp_addr);
                    chk1("mem_we", mem_we_o, exp_we);
                    chk("mem_wstrb", 32'(mem_wstrb_o), 32'(exp_wstrb));
                    if (exp_we) chk("mem_wdata", mem_wdata_o, exp_wdata);
                end
                saw_req = 1'b1; cap_addr = mem_addr_o; cap_wdata = mem_wdata_o;
                cap_wstrb = mem_wstrb_o; cap_we = mem_we_o;
            end
            chk1("ready_exclusive", lsu_ready_o && (mem_req_o || wbu_valid_o), 1'b0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        monitor();
    endtask

    // Load result from the byte-lane arithmetic definition.
    function automatic logic [31:0] model_load(input logic [31:0] rdata, input int off,
                                               input int size, input bit uns);
        longint v;
        v = longint'(rdata) >> (8 * off);
        if (size == 0) begin
            v = v % 256;
            if (!uns && v >= 128) v = v - 256;
        end else if (size == 1) begin
            v = v % 65536;
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(rdata);
        end
        return v[31:0];
    endfunction

    task automatic run_txn(input string tag, input logic [1:0] op, input logic [1:0] size,
                           input bit uns, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] rdata, input logic [4:0] rd, input logic [1:0] regs,
                           input bit regw, input logic [31:0] pc, input int gnt_dly,
                           input int rv_dly, input bit stray, input int stall);
        bit   is_mem, mis, tmo, waiting, was_req;
        int   off, exp_lat, cyc, req_n, wait_n;
        logic [31:0] d;
        off    = int'(addr % 32'd4);
        is_mem = (op == 2'd1) || (op == 2'd2);
        mis    = is_mem && ((size == 2'd1 && off % 2 == 1) || (size == 2'd2 && off != 0));
        tmo    = is_mem && !mis && (gnt_dly >= TB_MAX_WAIT);
        exp_lat = (!is_mem || mis) ? 0 : (tmo ? TB_MAX_WAIT : gnt_dly + rv_dly + 2);
        d = data;
        exp_result     = (op == 2'd1) ? model_load(rdata, off, int'(size), uns) : addr;
        exp_chk_result = !(mis || tmo) && (op != 2'd2);
        exp_rd = rd; exp_pc = pc;
        exp_regs = (op == 2'd1) ? 2'd0 : regs;
        exp_regw = regw && (op != 2'd2) && !mis && !tmo;
        exp_mis = mis; exp_to = tmo;
        exp_addr = addr - (addr % 32'd4);
        exp_we = (op == 2'd2);
        exp_wdata = (size == 2'd0) ? (d & 32'hFF) * 32'h01010101 :
                    (size == 2'd1) ? (d & 32'hFFFF) * 32'h00010001 : d;
        exp_wstrb = (op != 2'd2) ? 4'h0 : (size == 2'd0) ? 4'(1 << off) :
                    (size == 2'd1) ? 4'(3 << off) : 4'hF;
        exp_wb_armed = 1'b1;
        exp_mem_armed = is_mem && !mis;
        saw_req = 1'b0;
        exu_result_i = addr; store_data_i = data; mem_op_i = op; mem_size_i = size;
        mem_unsigned_i = uns; rd_i = rd; regS_i = regs; RegW_i = regw; PC_i = pc;
        wbu_ready_i = 1'b1;
        exu_valid_i = 1'b1;
        cyc = 0;
        while (!lsu_ready_o && cyc < 20) begin tick(); cyc++; end
        chk1({tag, "_ready"}, lsu_ready_o, 1'b1);
        tick();
        exu_valid_i = 1'b0;
        exu_result_i = ~addr; store_data_i = ~data; rd_i = ~rd; PC_i = ~pc;
        mem_op_i = 2'd0; mem_size_i = ~size; mem_unsigned_i = ~uns; RegW_i = ~regw;
        waiting = 1'b0; req_n = 0; wait_n = 0; cyc = 0;
        while (!wbu_valid_o && cyc < 40) begin
            was_req      = mem_req_o;
            mem_gnt_i    = was_req && (req_n >= gnt_dly);
            mem_rvalid_i = waiting ? (wait_n >= rv_dly) : stray;
            mem_rdata_i  = waiting ? rdata : 32'hA5A5_5A5A;
            tick();
            if (waiting) begin
                if (mem_rvalid_i) waiting = 1'b0; else wait_n++;
            end else if (was_req) begin
                if (mem_gnt_i) begin waiting = 1'b1; wait_n = 0; end else req_n++;
            end
            cyc++;
        end
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        last_lat = cyc;
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        if (stall > 0) begin
            wbu_ready_i = 1'b0;
            for (int i = 0; i < stall; i++) begin
                tick();
                chk1({tag, "_stall_valid"}, wbu_valid_o, 1'b1);
            end
            wbu_ready_i = 1'b1;
        end
        tick();
        wbu_ready_i = 1'b0;
        exp_wb_armed = 1'b0; exp_mem_armed = 1'b0;
        chk1({tag, "_valid_drop"}, wbu_valid_o, 1'b0);
        chk1({tag, "_ready_back"}, lsu_ready_o, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        exu_valid_i = 1'b0; exu_result_i = 32'h0; store_data_i = 32'h0; mem_op_i = 2'd0;
        mem_size_i = 2'd0; mem_unsigned_i = 1'b0; rd_i = 5'd0; regS_i = 2'd0; RegW_i = 1'b0;
        PC_i = 32'h0; wbu_ready_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        mem_rdata_i = 32'h0; last_lat = 0;
        #12;
        chk1("reset_outputs_zero", |{lsu_ready_o, wbu_valid_o, wbu_result_o, wbu_rd_o, wbu_regS_o,
             wbu_RegW_o, wbu_PC_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
             misalign_o, timeout_o}, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk1("ready_before_edge", lsu_ready_o, 1'b0);
        tick();
        chk1("ready_after_reset", lsu_ready_o, 1'b1);

        run_txn("alu", 2'd0, 2'd2, 1'b0, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 2'd1, 1'b1, 32'h8000_0000, 0, 0, 1'b0, 0);
        chk("lit_alu_result", cap_result, 32'h0000_1234);
        chk("lit_alu_rd", 32'(cap_rd), 32'd5);
        chk1("lit_alu_regw", cap_regw, 1'b1);
        chk("lit_alu_latency", 32'(last_lat), 32'd0);

        run_txn("lb", 2'd1, 2'd0, 1'b0, 32'h8000_0003, 32'h0, 32'h80FF_0000, 5'd7, 2'd1, 1'b1, 32'h8000_0004, 0, 0, 1'b0, 1);
        chk("lit_lb_result", cap_result, 32'hFFFF_FF80);
        chk("lit_lb_addr", cap_addr, 32'h8000_0000);
        chk("lit_lb_regs", 32'(cap_regs), 32'd0);
        chk("lit_lb_latency", 32'(last_lat), 32'd2);

        run_txn("sh", 2'd2, 2'd1, 1'b0, 32'h8000_0002, 32'hABCD_1234, 32'h0, 5'd9, 2'd0, 1'b1, 32'h8000_0008, 1, 0, 1'b1, 0);
        chk("lit_sh_wdata", cap_wdata, 32'h1234_1234);
        chk("lit_sh_wstrb", 32'(cap_wstrb), 32'hC);
        chk1("lit_sh_we", cap_we, 1'b1);
        chk1("lit_sh_regw", cap_regw, 1'b0);

        run_txn("lw_mis", 2'd1, 2'd2, 1'b0, 32'h8000_0006, 32'h0, 32'h0, 5'd3, 2'd0, 1'b1, 32'h8000_000C, 0, 0, 1'b0, 3);
        chk1("lit_lwmis_flag", cap_mis, 1'b1);
        chk1("lit_lwmis_regw", cap_regw, 1'b0);
        chk1("lit_lwmis_noreq", saw_req, 1'b0);

        run_txn("lbu", 2'd1, 2'd0, 1'b1, 32'h8000_0000, 32'h0, 32'h1234_56F0, 5'd10, 2'd2, 1'b1, 32'h8000_0010, 0, 1, 1'b0, 0);
        chk("lit_lbu_result", cap_result, 32'h0000_00F0);
        run_txn("lh", 2'd1, 2'd1, 1'b0, 32'h8000_0002, 32'h0, 32'h8001_7FFF, 5'd11, 2'd0, 1'b1, 32'h8000_0014, 1, 0, 1'b0, 0);
        chk("lit_lh_result", cap_result, 32'hFFFF_8001);
        run_txn("lhu", 2'd1, 2'd1, 1'b1, 32'h8000_0000, 32'h0, 32'h1234_FFFF, 5'd12, 2'd0, 1'b1, 32'h8000_0018, 0, 0, 1'b0, 0);
        run_txn("lw", 2'd1, 2'd2, 1'b0, 32'h8000_0008, 32'h0, 32'hDEAD_BEEF, 5'd13, 2'd0, 1'b1, 32'h8000_001C, 0, 1, 1'b0, 2);
        run_txn("sb", 2'd2, 2'd0, 1'b0, 32'h8000_0001, 32'h0000_00A5, 32'h0, 5'd14, 2'd0, 1'b1, 32'h8000_0020, 0, 0, 1'b0, 0);
        chk("lit_sb_wdata", cap_wdata, 32'hA5A5_A5A5);
        chk("lit_sb_wstrb", 32'(cap_wstrb), 32'h2);
        run_txn("sw", 2'd2, 2'd2, 1'b0, 32'h8000_0004, 32'hCAFE_F00D, 32'h0, 5'd15, 2'd0, 1'b1, 32'h8000_0024, 1, 0, 1'b0, 0);
        run_txn("op3", 2'd3, 2'd2, 1'b0, 32'h0000_0003, 32'h0, 32'h0, 5'd16, 2'd3, 1'b1, 32'h8000_0028, 0, 0, 1'b0, 0);
        run_txn("lh_mis", 2'd1, 2'd1, 1'b1, 32'h8000_0011, 32'h0, 32'h0, 5'd17, 2'd1, 1'b1, 32'h8000_002C, 0, 0, 1'b0, 0);
        run_txn("tmo", 2'd1, 2'd2, 1'b0, 32'h8000_0010, 32'h0, 32'h0, 5'd18, 2'd0, 1'b1, 32'h8000_0030, 99, 0, 1'b0, 1);
        chk1("lit_tmo_flag", cap_to, 1'b1);
        chk1("lit_tmo_regw", cap_regw, 1'b0);
        chk("lit_tmo_latency", 32'(last_lat), 32'd4);

        // Reset while waiting for rvalid: the transaction must vanish.
        exp_wb_armed = 1'b0; exp_mem_armed = 1'b1;
        exp_addr = 32'h8000_0020; exp_we = 1'b0; exp_wstrb = 4'h0;
        exu_result_i = 32'h8000_0020; mem_op_i = 2'd1; mem_size_i = 2'd2; RegW_i = 1'b1;
        exu_valid_i = 1'b1;
        tick();
        exu_valid_i = 1'b0; mem_op_i = 2'd0;
        chk1("rst_txn_req", mem_req_o, 1'b1);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        chk1("rst_txn_in_wait", mem_req_o | wbu_valid_o, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk1("rst_mid_outputs_zero", |{lsu_ready_o, wbu_valid_o, wbu_result_o, wbu_rd_o, wbu_regS_o,
             wbu_RegW_o, wbu_PC_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
             misalign_o, timeout_o}, 1'b0);
        exp_mem_armed = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_2222;
        #1;
        chk1("rst_mid_ready_low", lsu_ready_o, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("stray_rvalid_no_valid", wbu_valid_o, 1'b0);
            chk1("stray_rvalid_ready", lsu_ready_o, 1'b1);
        end
        mem_rvalid_i = 1'b0;

        run_txn("alu2", 2'd0, 2'd0, 1'b0, 32'h5555_AAAA, 32'h0, 32'h0, 5'd31, 2'd2, 1'b0, 32'h8000_0040, 0, 0, 1'b0, 1);
        chk("lit_alu2_result", cap_result, 32'h5555_AAAA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
